// File: rtl/control_multiciclo_pkg.sv
// control_multiciclo_pkg: opcodes, ALU function codes, FSM states and decode helpers
package control_multiciclo_pkg;
  localparam logic [5:0] OP_ADD  = 6'b001111;
  localparam logic [5:0] OP_SUB  = 6'b000110;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000001;
  localparam logic [5:0] OP_SLT  = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_BJ   = 3'b001;
  localparam logic [2:0] ALU_R    = 3'b010;
  localparam logic [2:0] ALU_ADDI = 3'b011;
  localparam logic [2:0] ALU_ORI  = 3'b100;
  localparam logic [2:0] ALU_ANDI = 3'b101;
  localparam logic [2:0] ALU_SLTI = 3'b110;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  function automatic logic is_r(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
  endfunction
  function automatic logic is_i(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
  endfunction
  function automatic logic [2:0] alu_code(input logic [5:0] op);
    return is_r(op)      ? ALU_R :
           op == OP_ADDI ? ALU_ADDI :
           op == OP_ORI  ? ALU_ORI :
           op == OP_ANDI ? ALU_ANDI :
           op == OP_SLTI ? ALU_SLTI :
           (op == OP_BEQ || op == OP_J) ? ALU_BJ : ALU_ADD;
  endfunction
endpackage

// File: rtl/control_multiciclo_mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags the cycle that hits the timeout
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  logic [W-1:0] r_cnt;
  // wait counter: cleared outside waits, advanced on each unanswered request
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_expire = i_en && (r_cnt == W'(MEM_TIMEOUT - 2));
endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle MIPS-subset control FSM with memory handshake and trap
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     op_code,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_we,
  output logic                pc_we,
  output logic                branch,
  output logic                jump,
  output logic                reg_dst,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                fault,
  output logic [CNT_W-1:0]    instr_count
);
  state_t r_state, w_next;
  logic [OP_W-1:0] r_op;
  logic [CNT_W-1:0] r_count;
  logic w_wait, w_expire, w_retire;
  logic [ALU_OP_W-1:0] w_alu;
  assign w_wait = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign w_alu = alu_code(r_op);
  assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);
  assign fault = (r_state == S_TRAP) && !rst;
  assign instr_count = r_count;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_clr(!w_wait || mem_ready),
    .i_en(w_wait && !mem_ready),
    .o_expire(w_expire)
  );
  // state, latched opcode and retired count; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= op_code;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  // next state and datapath strobes; everything forced low while rst is held
  always_comb begin
    w_next = r_state;
    mem_req = 1'b0;
    mem_write = 1'b0;
    iord = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
    reg_dst = 1'b0;
    alu_src = 1'b0;
    alu_op = '0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next = mem_ready ? S_DECODE : w_expire ? S_TRAP : S_FETCH;
        mem_req = 1'b1;
        ir_we = mem_ready;
        pc_we = mem_ready;
      end
      S_DECODE:
        w_next = is_r(op_code) ? S_EXEC_R :
                 is_i(op_code) ? S_EXEC_I :
                 (op_code == OP_LW || op_code == OP_SW) ? S_MEM_ADDR :
                 op_code == OP_BEQ ? S_BRANCH :
                 op_code == OP_J   ? S_JUMP : S_TRAP;
      S_EXEC_R: begin
        w_next = S_WB;
        reg_dst = 1'b1;
        alu_op = w_alu;
      end
      S_EXEC_I: begin
        w_next = S_WB;
        alu_src = 1'b1;
        alu_op = w_alu;
      end
      S_MEM_ADDR: begin
        w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        alu_src = 1'b1;
        alu_op = w_alu;
      end
      S_MEM_RD: begin
        w_next = mem_ready ? S_WB : w_expire ? S_TRAP : S_MEM_RD;
        mem_req = 1'b1;
        iord = 1'b1;
        mem_to_reg = 1'b1;
        alu_op = w_alu;
      end
      S_MEM_WR: begin
        w_next = mem_ready ? S_FETCH : w_expire ? S_TRAP : S_MEM_WR;
        mem_req = 1'b1;
        iord = 1'b1;
        mem_write = 1'b1;
        alu_op = w_alu;
      end
      S_WB: begin
        w_next = S_FETCH;
        reg_write = 1'b1;
        reg_dst = is_r(r_op);
        mem_to_reg = (r_op == OP_LW);
      end
      S_BRANCH: begin
        w_next = S_FETCH;
        branch = 1'b1;
        alu_op = w_alu;
      end
      S_JUMP: begin
        w_next = S_FETCH;
        jump = 1'b1;
        pc_we = 1'b1;
      end
      default: w_next = S_TRAP;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_write = 1'b0;
      iord = 1'b0;
      ir_we = 1'b0;
      pc_we = 1'b0;
      branch = 1'b0;
      jump = 1'b0;
      reg_dst = 1'b0;
      alu_src = 1'b0;
      alu_op = '0;
      mem_to_reg = 1'b0;
      reg_write = 1'b0;
    end
  end
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: table-driven and directed checks of the multi-cycle control FSM
module tb_control_multiciclo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op_code = 6'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_write, iord, ir_we, pc_we, branch, jump;
  logic reg_dst, alu_src, mem_to_reg, reg_write, fault;
  logic [2:0] alu_op;
  logic [31:0] instr_count;
  logic [14:0] act;
  int n_cmp = 0;
  int n_err = 0;
  // bit order: mem_req mem_write iord | ir_we pc_we | branch jump | reg_dst alu_src | alu_op | mem_to_reg reg_write fault
  localparam logic [14:0] E_F1   = 15'b100_11_00_00_000_000;
  localparam logic [14:0] E_F0   = 15'b100_00_00_00_000_000;
  localparam logic [14:0] E_DEC  = 15'b000_00_00_00_000_000;
  localparam logic [14:0] E_EXR  = 15'b000_00_00_10_010_000;
  localparam logic [14:0] E_WBR  = 15'b000_00_00_10_000_010;
  localparam logic [14:0] E_MA   = 15'b000_00_00_01_000_000;
  localparam logic [14:0] E_MRD  = 15'b101_00_00_00_000_100;
  localparam logic [14:0] E_WBL  = 15'b000_00_00_00_000_110;
  localparam logic [14:0] E_MWR  = 15'b111_00_00_00_000_000;
  localparam logic [14:0] E_BR   = 15'b000_00_10_00_001_000;
  localparam logic [14:0] E_JMP  = 15'b000_01_01_00_000_000;
  localparam logic [14:0] E_EXI  = 15'b000_00_00_01_110_000;
  localparam logic [14:0] E_WBI  = 15'b000_00_00_00_000_010;
  localparam logic [14:0] E_TRAP = 15'b000_00_00_00_000_001;
  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [14:0] exp;
    logic [31:0] cnt;
    string       tag;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  control_multiciclo dut (
    .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .branch(branch), .jump(jump), .reg_dst(reg_dst),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .fault(fault), .instr_count(instr_count)
  );

  assign act = {mem_req, mem_write, iord, ir_we, pc_we, branch, jump,
                reg_dst, alu_src, alu_op, mem_to_reg, reg_write, fault};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [14:0] exp,
                     input logic [31:0] cnt, input string tag);
    vec_t v;
    v.op = op; v.rdy = rdy; v.exp = exp; v.cnt = cnt; v.tag = tag;
    tbl.push_back(v);
  endtask

  task automatic step(input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst = 1'b0;
    op_code = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check({tag, "_rst_out"}, 32'(act), 32'(E_DEC));
    check({tag, "_rst_cnt"}, instr_count, 32'd0);
  endtask

  initial begin
    add(6'b001111, 1'b1, E_F1,  0, "add_fetch");
    add(6'b001111, 1'b1, E_DEC, 0, "add_decode");
    add(6'b001111, 1'b1, E_EXR, 0, "add_exec");
    add(6'b001111, 1'b1, E_WBR, 0, "add_wb");
    add(6'b100011, 1'b1, E_F1,  1, "lw_fetch");
    add(6'b100011, 1'b1, E_DEC, 1, "lw_decode");
    add(6'b100011, 1'b1, E_MA,  1, "lw_addr");
    add(6'b100011, 1'b0, E_MRD, 1, "lw_rd_w0");
    add(6'b100011, 1'b0, E_MRD, 1, "lw_rd_w1");
    add(6'b100011, 1'b0, E_MRD, 1, "lw_rd_w2");
    add(6'b100011, 1'b1, E_MRD, 1, "lw_rd_ok");
    add(6'b100011, 1'b1, E_WBL, 1, "lw_wb");
    add(6'b101011, 1'b1, E_F1,  2, "sw_fetch");
    add(6'b101011, 1'b1, E_DEC, 2, "sw_decode");
    add(6'b101011, 1'b1, E_MA,  2, "sw_addr");
    add(6'b101011, 1'b1, E_MWR, 2, "sw_wr");
    add(6'b000100, 1'b1, E_F1,  3, "beq_fetch");
    add(6'b000100, 1'b1, E_DEC, 3, "beq_decode");
    add(6'b000100, 1'b1, E_BR,  3, "beq_branch");
    add(6'b000010, 1'b1, E_F1,  4, "j_fetch");
    add(6'b000010, 1'b1, E_DEC, 4, "j_decode");
    add(6'b000010, 1'b1, E_JMP, 4, "j_jump");
    add(6'b001010, 1'b1, E_F1,  5, "slti_fetch");
    add(6'b001010, 1'b1, E_DEC, 5, "slti_decode");
    add(6'b001010, 1'b1, E_EXI, 5, "slti_exec");
    add(6'b001010, 1'b1, E_WBI, 5, "slti_wb");
    add(6'b000000, 1'b0, E_F0,  6, "next_fetch_wait");

    do_reset("init");
    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].rdy);
      check({tbl[i].tag, "_out"}, 32'(act), 32'(tbl[i].exp));
      check({tbl[i].tag, "_cnt"}, instr_count, tbl[i].cnt);
    end

    // illegal opcode after one retired BEQ: trap, no more requests, count frozen
    do_reset("ill");
    step(6'b000100, 1'b1);
    step(6'b000100, 1'b1);
    step(6'b000100, 1'b1);
    step(6'b111111, 1'b1);
    check("ill_fetch_cnt", instr_count, 32'd1);
    step(6'b111111, 1'b1);
    check("ill_decode_out", 32'(act), 32'(E_DEC));
    for (int k = 0; k < 4; k++) begin
      step(6'b000000, 1'b1);
      check("ill_trap_out", 32'(act), 32'(E_TRAP));
      check("ill_trap_cnt", instr_count, 32'd1);
    end

    // fetch never answered: 15 waiting cycles, then trap
    do_reset("tmo");
    for (int k = 1; k <= 15; k++) begin
      step(6'b000000, 1'b0);
      check($sformatf("tmo_wait%0d", k), 32'(act), 32'(E_F0));
    end
    step(6'b000000, 1'b0);
    check("tmo_trap", 32'(act), 32'(E_TRAP));
    step(6'b000000, 1'b1);
    check("tmo_trap_ready_ignored", 32'(act), 32'(E_TRAP));

    // reset asserted mid-wait in MEM_RD
    do_reset("rmid");
    step(6'b000100, 1'b1);
    step(6'b000100, 1'b1);
    step(6'b000100, 1'b1);
    step(6'b100011, 1'b1);
    step(6'b100011, 1'b1);
    step(6'b100011, 1'b1);
    step(6'b100011, 1'b0);
    step(6'b100011, 1'b0);
    check("rmid_wait_out", 32'(act), 32'(E_MRD));
    check("rmid_wait_cnt", instr_count, 32'd1);
    rst = 1'b1;
    #1;
    check("rmid_abort_out", 32'(act), 32'(E_DEC));
    check("rmid_abort_cnt", instr_count, 32'd0);
    step(6'b100011, 1'b1);
    check("rmid_release_fetch", 32'(act), 32'(E_F1));
    step(6'b100011, 1'b1);
    check("rmid_release_decode", 32'(act), 32'(E_DEC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
